// File: rtl/fetch_prefetch_unit.sv
// Prefetching fetch stage: credit-limited imem requests, in-order response buffering
// with PC tags, and a decode-facing fetch queue that is flushed on redirect.
module fetch_prefetch_unit #(
    parameter int               XLEN            = 32,
    parameter int               INST_W          = 32,
    parameter logic [XLEN-1:0]  RESET_PC        = '0,
    parameter int               FQ_DEPTH        = 4,
    parameter int               MAX_OUTSTANDING = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        stall_pipeline,
    input  logic                        redirect_valid,
    input  logic [XLEN-1:0]             redirect_pc,
    output logic                        imem_req_valid,
    input  logic                        imem_req_ready,
    output logic [XLEN-1:0]             imem_req_addr,
    input  logic                        imem_rsp_valid,
    input  logic [INST_W-1:0]           imem_rsp_data,
    output logic                        dec_valid,
    output logic [XLEN-1:0]             dec_pc,
    output logic [INST_W-1:0]           dec_inst,
    output logic [$clog2(FQ_DEPTH):0]   fq_count
);
    localparam int FQ_PW  = $clog2(FQ_DEPTH);
    localparam int CW     = FQ_PW + 1;
    localparam int TAG_PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int OW     = $clog2(MAX_OUTSTANDING + 1);

    // Handshake: a request transfers on a cycle where imem_req_valid && imem_req_ready;
    // an unaccepted request may be withdrawn only by a redirect. Responses are in order,
    // one per accepted request, and are never back-pressured.

    logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
    logic [OW-1:0]     outstanding_q, outstanding_d;
    logic [OW-1:0]     drop_cnt_q, drop_cnt_d;
    logic [CW-1:0]     count_q, count_d;
    logic [FQ_PW-1:0]  fq_wr_q, fq_wr_d, fq_rd_q, fq_rd_d;
    logic [XLEN-1:0]   fq_pc_q [FQ_DEPTH];
    logic [XLEN-1:0]   fq_pc_d [FQ_DEPTH];
    logic [INST_W-1:0] fq_inst_q [FQ_DEPTH];
    logic [INST_W-1:0] fq_inst_d [FQ_DEPTH];
    logic [TAG_PW-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
    logic [XLEN-1:0]   tag_pc_q [MAX_OUTSTANDING];
    logic [XLEN-1:0]   tag_pc_d [MAX_OUTSTANDING];

    logic req_valid, accept, rsp_fire, rsp_keep, pop;

    function automatic logic [TAG_PW-1:0] tag_next(input logic [TAG_PW-1:0] p);
        return (p == TAG_PW'(MAX_OUTSTANDING - 1)) ? '0 : p + TAG_PW'(1);
    endfunction

    // Responses with nothing outstanding (e.g. left over from before a reset) are ignored.
    assign rsp_fire  = imem_rsp_valid && (outstanding_q != '0);
    assign rsp_keep  = rsp_fire && (drop_cnt_q == '0);
    assign req_valid = !rst && !redirect_valid
                       && (int'(outstanding_q) < MAX_OUTSTANDING)
                       && ((int'(count_q) + int'(outstanding_q)) < FQ_DEPTH);
    assign accept    = req_valid && imem_req_ready;
    assign pop       = dec_valid && !stall_pipeline;

    assign imem_req_valid = req_valid;
    assign imem_req_addr  = fetch_pc_q;
    assign fq_count       = count_q;
    assign dec_valid      = (count_q != '0);
    assign dec_pc         = dec_valid ? fq_pc_q[fq_rd_q] : '0;
    assign dec_inst       = dec_valid ? fq_inst_q[fq_rd_q] : '0;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        outstanding_d = outstanding_q;
        drop_cnt_d    = drop_cnt_q;
        count_d       = count_q;
        fq_wr_d       = fq_wr_q;
        fq_rd_d       = fq_rd_q;
        fq_pc_d       = fq_pc_q;
        fq_inst_d     = fq_inst_q;
        tag_wr_d      = tag_wr_q;
        tag_rd_d      = tag_rd_q;
        tag_pc_d      = tag_pc_q;

        if (accept && !rsp_fire) begin
            outstanding_d = outstanding_q + OW'(1);
        end else if (!accept && rsp_fire) begin
            outstanding_d = outstanding_q - OW'(1);
        end

        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
            // Everything still in flight after this cycle belongs to the old path.
            drop_cnt_d = outstanding_d;
            count_d    = '0;
            fq_wr_d    = '0;
            fq_rd_d    = '0;
            tag_wr_d   = '0;
            tag_rd_d   = '0;
        end else begin
            if (accept) begin
                fetch_pc_d         = fetch_pc_q + XLEN'(4);
                tag_pc_d[tag_wr_q] = fetch_pc_q;
                tag_wr_d           = tag_next(tag_wr_q);
            end
            if (rsp_fire && (drop_cnt_q != '0)) begin
                drop_cnt_d = drop_cnt_q - OW'(1);
            end
            // Stale tags were flushed at the redirect, so only kept responses consume a tag.
            if (rsp_keep) begin
                fq_pc_d[fq_wr_q]   = tag_pc_q[tag_rd_q];
                fq_inst_d[fq_wr_q] = imem_rsp_data;
                fq_wr_d            = fq_wr_q + FQ_PW'(1);
                tag_rd_d           = tag_next(tag_rd_q);
            end
            if (pop) begin
                fq_rd_d = fq_rd_q + FQ_PW'(1);
            end
            if (rsp_keep && !pop) begin
                count_d = count_q + CW'(1);
            end else if (!rsp_keep && pop) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            count_q       <= '0;
            fq_wr_q       <= '0;
            fq_rd_q       <= '0;
            fq_pc_q       <= '{default: '0};
            fq_inst_q     <= '{default: '0};
            tag_wr_q      <= '0;
            tag_rd_q      <= '0;
            tag_pc_q      <= '{default: '0};
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            count_q       <= count_d;
            fq_wr_q       <= fq_wr_d;
            fq_rd_q       <= fq_rd_d;
            fq_pc_q       <= fq_pc_d;
            fq_inst_q     <= fq_inst_d;
            tag_wr_q      <= tag_wr_d;
            tag_rd_q      <= tag_rd_d;
            tag_pc_q      <= tag_pc_d;
        end
    end

    always @(posedge clk) begin
        if (!rst) begin
            assert (!(imem_rsp_valid && (outstanding_q == '0)));
        end
    end
endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit: an in-order fixed-latency imem model,
// hand-computed expectations and a per-test expected-PC queue.
module tb_fetch_prefetch_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_pipeline = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        dec_valid;
  logic [31:0] dec_pc;
  logic [31:0] dec_inst;
  logic [2:0]  fq_count;

  int n_checks = 0;
  int n_pass = 0;

  logic [31:0] pend_addr[$];
  int          pend_due[$];
  logic [31:0] exp_q[$];
  int cyc = 0;
  int rsp_lat = 1;
  int acc_count = 0;
  int max_inflight = 0;

  fetch_prefetch_unit dut (
    .clk(clk), .rst(rst), .stall_pipeline(stall_pipeline),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .dec_valid(dec_valid), .dec_pc(dec_pc),
    .dec_inst(dec_inst), .fq_count(fq_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return 32'hC0DE_0000 | {16'h0000, a[15:0]};
  endfunction

  // imem model: records accepts at the negedge before the edge, answers in order after rsp_lat cycles
  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        pend_addr.delete();
        pend_due.delete();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
      end else begin
        if (imem_req_valid && imem_req_ready) begin
          pend_addr.push_back(imem_req_addr);
          pend_due.push_back(cyc + rsp_lat);
          acc_count++;
        end
        if (pend_addr.size() > max_inflight) max_inflight = pend_addr.size();
        if (pend_due.size() != 0 && pend_due[0] <= cyc) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = inst_of(pend_addr[0]);
          void'(pend_addr.pop_front());
          void'(pend_due.pop_front());
        end else begin
          imem_rsp_valid = 1'b0;
          imem_rsp_data  = '0;
        end
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    step();
    step();
    acc_count = 0;
    max_inflight = 0;
    exp_q.delete();
    rst = 1'b0;
  endtask

  task automatic wait_dec(input string tag, input int bound);
    int n = 0;
    while (!dec_valid && n < bound) begin
      step();
      n++;
    end
    check_eq({tag, "_dec_timeout"}, 32'(dec_valid), 32'd1);
  endtask

  initial begin
    logic [31:0] e;
    int seen;

    // reset state
    step();
    step();
    check_eq("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check_eq("rst_dec_valid", 32'(dec_valid), 32'd0);
    check_eq("rst_fq_count", 32'(fq_count), 32'd0);
    check_eq("rst_dec_pc", dec_pc, 32'h0);
    check_eq("rst_dec_inst", dec_inst, 32'h0);

    // t1: streaming, latency 1
    stall_pipeline = 1'b0; imem_req_ready = 1'b1; rsp_lat = 1;
    do_reset();
    #1;
    check_eq("t1_req_valid", 32'(imem_req_valid), 32'd1);
    check_eq("t1_addr0", imem_req_addr, 32'h0);
    step();
    check_eq("t1_addr1", imem_req_addr, 32'h4);
    check_eq("t1_dec_empty", 32'(dec_valid), 32'd0);
    exp_q = '{32'h0, 32'h4, 32'h8};
    for (int i = 0; i < 3; i++) begin
      step();
      e = exp_q.pop_front();
      check_eq("t1_dec_valid", 32'(dec_valid), 32'd1);
      check_eq("t1_dec_pc", dec_pc, e);
      check_eq("t1_dec_inst", dec_inst, inst_of(e));
    end

    // t2: stalled decode fills the queue, then drains in order
    stall_pipeline = 1'b1; rsp_lat = 1;
    do_reset();
    for (int i = 0; i < 8; i++) step();
    check_eq("t2_accepts", 32'(acc_count), 32'd4);
    check_eq("t2_fq_count", 32'(fq_count), 32'd4);
    check_eq("t2_req_valid", 32'(imem_req_valid), 32'd0);
    check_eq("t2_addr", imem_req_addr, 32'h10);
    check_eq("t2_head_pc", dec_pc, 32'h0);
    check_eq("t2_head_inst", dec_inst, 32'hC0DE_0000);
    stall_pipeline = 1'b0;
    exp_q = '{32'h4, 32'h8, 32'hC, 32'h10};
    step();
    check_eq("t2_resume_valid", 32'(imem_req_valid), 32'd1);
    check_eq("t2_resume_addr", imem_req_addr, 32'h10);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      e = exp_q.pop_front();
      check_eq("t2_drain_pc", dec_pc, e);
    end

    // t3: latency 3 limits in-flight requests to 2
    stall_pipeline = 1'b0; rsp_lat = 3;
    do_reset();
    seen = 0;
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(32'(i * 4));
    for (int i = 0; i < 20; i++) begin
      step();
      if (dec_valid) begin
        e = exp_q.pop_front();
        check_eq("t3_order_pc", dec_pc, e);
        seen++;
      end
    end
    check_eq("t3_max_inflight", 32'(max_inflight), 32'd2);
    check_eq("t3_entries", 32'(seen), 32'd9);

    // t4: redirect with two requests in flight
    stall_pipeline = 1'b0; rsp_lat = 3;
    do_reset();
    step();
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h103;
    #1;
    check_eq("t4_valid_in_redirect", 32'(imem_req_valid), 32'd0);
    step();
    redirect_valid = 1'b0;
    #1;
    check_eq("t4_target_addr", imem_req_addr, 32'h100);
    check_eq("t4_fq_empty", 32'(fq_count), 32'd0);
    step();
    check_eq("t4_issue_valid", 32'(imem_req_valid), 32'd1);
    check_eq("t4_issue_addr", imem_req_addr, 32'h100);
    wait_dec("t4", 20);
    check_eq("t4_first_pc", dec_pc, 32'h100);
    check_eq("t4_first_inst", dec_inst, 32'hC0DE_0100);

    // t5a: redirect with a pop at a full queue
    stall_pipeline = 1'b1; rsp_lat = 1;
    do_reset();
    for (int i = 0; i < 6; i++) step();
    check_eq("t5a_full", 32'(fq_count), 32'd4);
    stall_pipeline = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h80;
    step();
    redirect_valid = 1'b0;
    check_eq("t5a_flushed", 32'(fq_count), 32'd0);
    check_eq("t5a_no_dec", 32'(dec_valid), 32'd0);
    #1;
    check_eq("t5a_addr", imem_req_addr, 32'h80);
    step();
    check_eq("t5a_no_spurious", 32'(dec_valid), 32'd0);

    // t5b: redirect in the same cycle as a response and a pop
    stall_pipeline = 1'b1; rsp_lat = 1;
    do_reset();
    for (int i = 0; i < 4; i++) step();
    check_eq("t5b_pre_count", 32'(fq_count), 32'd3);
    stall_pipeline = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h40;
    step();
    redirect_valid = 1'b0;
    check_eq("t5b_flushed", 32'(fq_count), 32'd0);
    check_eq("t5b_no_dec", 32'(dec_valid), 32'd0);
    #1;
    check_eq("t5b_valid", 32'(imem_req_valid), 32'd1);
    check_eq("t5b_addr", imem_req_addr, 32'h40);
    wait_dec("t5b", 10);
    check_eq("t5b_first_pc", dec_pc, 32'h40);

    // t6: imem not ready holds the address, then async reset mid-stall
    stall_pipeline = 1'b1; rsp_lat = 1; imem_req_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 3; i++) step();
    imem_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("t6_addr_stable", imem_req_addr, 32'hC);
    end
    check_eq("t6_valid_held", 32'(imem_req_valid), 32'd1);
    check_eq("t6_pre_count", 32'(fq_count), 32'd3);
    #3;
    rst = 1'b1;
    #1;
    check_eq("t6_rst_valid", 32'(imem_req_valid), 32'd0);
    check_eq("t6_rst_count", 32'(fq_count), 32'd0);
    check_eq("t6_rst_dec_valid", 32'(dec_valid), 32'd0);
    check_eq("t6_rst_dec_pc", dec_pc, 32'h0);
    check_eq("t6_rst_addr", imem_req_addr, 32'h0);
    step();
    rst = 1'b0; imem_req_ready = 1'b1; stall_pipeline = 1'b0;
    #1;
    check_eq("t6_restart_valid", 32'(imem_req_valid), 32'd1);
    check_eq("t6_restart_addr", imem_req_addr, 32'h0);
    wait_dec("t6", 10);
    check_eq("t6_restart_pc", dec_pc, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
